// File: rtl/variable_node.sv
// variable_node: degree-3 variable-node processor for a min-sum LDPC decoder.
// It holds one channel LLR and takes one alpha triple per iteration. For each
// triple it returns three extrinsic betas and a hard decision.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   llr_load        capture llr_in and start a new codeword (any state)
//   llr_in[5:0]     channel LLR, 3.3 two's complement
//   alpha_valid     an alpha triple is presented
//   alpha_ready     the node takes the triple this cycle
//   alpha1..3[5:0]  check-to-variable messages, 2.4 two's complement
//   beta_valid      a beta triple is presented
//   beta_ready      downstream takes the betas this cycle
//   beta1..3[5:0]   variable-to-check messages, 3.3 two's complement
//   decision        hard decision: 1 when the posterior LLR is negative
//   iter_cnt        number of alpha triples accepted for this codeword
//   done            level: decoding of this codeword has finished
//
// Optional feature (macro VN_EARLY_TERM_EN): the node finishes early once the
// hard decision has stayed unchanged for STABLE_ITERS consecutive accepts.
//
// state | meaning
// IDLE  | no codeword loaded yet
// RUN   | iterating: issue betas and accept alpha triples
// DONE  | finished; decision is held until the next llr_load

module variable_node #(
    parameter int MAX_ITER     = 10,
    parameter int ITER_W       = 4,
    parameter int STABLE_ITERS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              llr_load,
    input  logic [5:0]        llr_in,
    input  logic              alpha_valid,
    output logic              alpha_ready,
    input  logic [5:0]        alpha1,
    input  logic [5:0]        alpha2,
    input  logic [5:0]        alpha3,
    output logic              beta_valid,
    input  logic              beta_ready,
    output logic [5:0]        beta1,
    output logic [5:0]        beta2,
    output logic [5:0]        beta3,
    output logic              decision,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  llr_q;

    // All arithmetic runs in 9-bit 5.4, which covers the full -160..155 range.
    logic signed [8:0] lam, a1s, a2s, a3s, l_sum, e1, e2, e3;
    logic [5:0]        b1_new, b2_new, b3_new;
    logic              dec_new;
    logic              accept;
    logic [ITER_W-1:0] iter_next;
    logic              term_hit;

    // Rounds half up, drops one fraction bit (5.4 -> 3.3) and clamps to six bits.
    function automatic logic [5:0] round_sat(input logic signed [8:0] e);
        logic signed [8:0] r;
        r = (e + 9'sd1) >>> 1;
        if (r > 9'sd31)
            return 6'b011111;
        else if (r < -9'sd32)
            return 6'b100000;
        else
            return r[5:0];
    endfunction

    assign lam   = {{2{llr_q[5]}}, llr_q, 1'b0};
    assign a1s   = {{3{alpha1[5]}}, alpha1};
    assign a2s   = {{3{alpha2[5]}}, alpha2};
    assign a3s   = {{3{alpha3[5]}}, alpha3};
    assign l_sum = lam + a1s + a2s + a3s;
    assign e1    = l_sum - a1s;
    assign e2    = l_sum - a2s;
    assign e3    = l_sum - a3s;

    assign b1_new  = round_sat(e1);
    assign b2_new  = round_sat(e2);
    assign b3_new  = round_sat(e3);
    assign dec_new = l_sum[8];

    // alpha_ready looks at beta_ready directly. This lets an accept and a beta
    // handoff happen in the same cycle, so the node sustains one triple per cycle.
    assign alpha_ready = (state == RUN) && (!beta_valid || beta_ready);
    // llr_load takes priority: an alpha that arrives in the same cycle is ignored.
    assign accept      = alpha_valid && alpha_ready && !llr_load;
    assign iter_next   = iter_cnt + ITER_W'(1);

`ifdef VN_EARLY_TERM_EN
    logic [ITER_W-1:0] stable_cnt;
    logic              have_dec;
    logic [ITER_W-1:0] stable_next;

    // The first accept of a codeword has no earlier decision to compare with.
    assign stable_next = (have_dec && (dec_new == decision)) ? stable_cnt + ITER_W'(1)
                                                             : '0;
    assign term_hit    = (iter_next == ITER_W'(MAX_ITER)) ||
                         (stable_next == ITER_W'(STABLE_ITERS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            have_dec   <= 1'b0;
        end else if (llr_load) begin
            stable_cnt <= '0;
            have_dec   <= 1'b0;
        end else if (accept) begin
            stable_cnt <= stable_next;
            have_dec   <= 1'b1;
        end
    end
`else
    logic unused_stable;
    assign unused_stable = ^STABLE_ITERS;
    assign term_hit      = (iter_next == ITER_W'(MAX_ITER));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            llr_q      <= '0;
            beta1      <= '0;
            beta2      <= '0;
            beta3      <= '0;
            beta_valid <= 1'b0;
            decision   <= 1'b0;
            iter_cnt   <= '0;
            done       <= 1'b0;
        end else if (llr_load) begin
            // Start a new codeword from any state. Any pending beta is dropped.
            state      <= RUN;
            llr_q      <= llr_in;
            beta1      <= llr_in;
            beta2      <= llr_in;
            beta3      <= llr_in;
            beta_valid <= 1'b1;
            iter_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            if (beta_valid && beta_ready)
                beta_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        iter_cnt <= iter_next;
                        decision <= dec_new;
                        if (term_hit) begin
                            // The last accept updates only the decision; no betas follow.
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            beta1      <= b1_new;
                            beta2      <= b2_new;
                            beta3      <= b3_new;
                            beta_valid <= 1'b1;
                        end
                    end
                end
                DONE:    done  <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
